// File: rtl/dmem_ctrl.sv
// Data memory controller: RISC-V byte/half/word loads and stores over a
// valid/ready request/response handshake with a programmable wait-state count.
//
// state  | meaning
// IDLE   | ready to accept a request
// WAIT   | counting down wait states before the memory access
// RESP   | response presented, held until the consumer accepts it
module dmem_ctrl #(
   parameter         DMEM_FILE   = "",
   parameter int     DEPTH       = 256,
   parameter int     WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         AW        = $clog2(DEPTH);
   // Response lands WAIT_CYCLES+1 edges after acceptance; WAIT_CYCLES=0 spends one cycle in WAIT.
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rdy_en_q;
   logic          we_q;
   logic [2:0]    funct3_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          go_resp;
   logic          rsp_hs;
   logic [AW-1:0] widx;
   logic [1:0]    lane;
   logic          oor;
   logic          bad_f3;
   logic          misalign;
   logic          fault;
   logic [31:0]   word;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [31:0]   load_val;
   logic [31:0]   wr_data;
   logic [3:0]    wr_mask;
   logic [31:0]   new_word;

   assign accept    = req_valid && req_ready;
   assign go_resp   = (state_q == S_WAIT) && (cnt_q == 4'd0);
   assign rsp_hs    = rsp_valid && rsp_ready;
   assign req_ready = rdy_en_q && (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_WAIT;
               cnt_d   = WAIT_LOAD;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      widx     = addr_q[AW+1:2];
      lane     = addr_q[1:0];
      oor      = (addr_q >> (AW + 2)) != 32'd0;
      word     = mem[widx];
      byte_v   = word[{lane, 3'b000} +: 8];
      half_v   = word[{lane[1], 4'b0000} +: 16];
      bad_f3   = 1'b0;
      misalign = 1'b0;
      load_val = '0;
      wr_data  = '0;
      wr_mask  = '0;
      case (funct3_q)
         3'd0: begin
            load_val = {{24{byte_v[7]}}, byte_v};
            wr_data  = {4{wdata_q[7:0]}};
            wr_mask  = 4'b0001 << lane;
         end
         3'd1: begin
            misalign = lane[0];
            load_val = {{16{half_v[15]}}, half_v};
            wr_data  = {2{wdata_q[15:0]}};
            wr_mask  = lane[1] ? 4'b1100 : 4'b0011;
         end
         3'd2: begin
            misalign = (lane != 2'd0);
            load_val = word;
            wr_data  = wdata_q;
            wr_mask  = 4'b1111;
         end
         3'd4: begin
            bad_f3   = we_q;
            load_val = {24'd0, byte_v};
         end
         3'd5: begin
            bad_f3   = we_q;
            misalign = lane[0];
            load_val = {16'd0, half_v};
         end
         default: bad_f3 = 1'b1;
      endcase
      fault    = bad_f3 || misalign || oor;
      new_word = word;
      for (int i = 0; i < 4; i++) begin
         if (wr_mask[i]) new_word[i*8 +: 8] = wr_data[i*8 +: 8];
      end
   end

   // Memory has no reset; state is forced to IDLE by reset, so a pending store never reaches here.
   always_ff @(posedge clk) begin
      if (go_resp && we_q && !fault) mem[widx] <= new_word;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         rdy_en_q <= 1'b0;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdy_en_q <= 1'b1;
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
         end
         if (go_resp) begin
            rdata_q <= (we_q || fault) ? 32'd0 : load_val;
            err_q   <= fault;
         end else if (rsp_hs) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed load/store/fault/back-pressure/reset scenarios
// plus random traffic against a byte-addressed reference memory.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int errs = 0;
   int checks = 0;

   logic [7:0] mbytes [1024];

   always #5 clk = ~clk;

   dmem_ctrl #(
      .DMEM_FILE   (""),
      .DEPTH       (256),
      .WAIT_CYCLES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   // Reference: little-endian byte memory of 4*256 bytes, sizes and faults from the ISA rules.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int          sz;
      bit          sgn;
      bit          ok;
      logic [31:0] v;
      sz = 0; sgn = 0; ok = 1; rd = '0; v = '0;
      case (f3)
         3'd0: begin sz = 1; sgn = 1; end
         3'd1: begin sz = 2; sgn = 1; end
         3'd2: sz = 4;
         3'd4: begin sz = 1; ok = !we; end
         3'd5: begin sz = 2; ok = !we; end
         default: ok = 0;
      endcase
      if (ok) ok = ((a % sz) == 0) && (a < 1024);
      er = !ok;
      if (!ok) return;
      if (we) begin
         for (int k = 0; k < sz; k++) mbytes[a + k] = wd[8*k +: 8];
      end else begin
         for (int k = 0; k < sz; k++) v[8*k +: 8] = mbytes[a + k];
         if (sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
         rd = v;
      end
   endfunction

   // Drives one request with rsp_ready as currently set; lat = edges from acceptance to rsp_valid.
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output bit to);
      to = 0; lat = 0; rd = '0; er = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
      if (!req_ready) begin
         to = 1; req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      while (!rsp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) begin
         to = 1;
         return;
      end
      rd = rsp_rdata; er = rsp_err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
         errs++;
         $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rdata=%h, want 0 0 0 00000000",
                  req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_ready_after_release: got %b want 1", req_ready);
      end
   endtask

   task automatic test_init();
      logic [31:0] rd, erd, d;
      logic        er, eer;
      int          lat;
      bit          to;
      for (int w = 0; w < 32; w++) begin
         d = $urandom;
         xact(1'b1, 3'd2, 32'(w*4), d, rd, er, lat, to);
         model(1'b1, 3'd2, 32'(w*4), d, erd, eer);
         checks++;
         if (to || er !== eer || rd !== erd) begin
            errs++;
            $display("FAIL init_sw[%0d]: got to=%0d err=%b rdata=%h, want to=0 err=%b rdata=%h",
                     w, to, er, rd, eer, erd);
         end
      end
   endtask

   task automatic test_sw_lw();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      bit          to;
      xact(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, er, lat, to);
      model(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, erd, eer);
      checks++;
      if (to || lat != 3) begin
         errs++;
         $display("FAIL sw_latency: got to=%0d lat=%0d, want to=0 lat=3", to, lat);
      end
      checks++;
      if (er !== 1'b0 || rd !== 32'd0) begin
         errs++;
         $display("FAIL sw_rsp: got err=%b rdata=%h, want 0 00000000", er, rd);
      end
      xact(1'b0, 3'd2, 32'h10, 32'd0, rd, er, lat, to);
      checks++;
      if (to || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
         errs++;
         $display("FAIL lw_after_sw: got to=%0d err=%b rdata=%h, want 0 0 deadbeef", to, er, rd);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      bit          to;
      logic [31:0] exp_v [3];
      logic [2:0]  f3s [3];
      logic [31:0] adr [3];
      exp_v = '{32'h1122_AA44, 32'hFFFF_FFAA, 32'h0000_00AA};
      f3s   = '{3'd2, 3'd0, 3'd4};
      adr   = '{32'h20, 32'h21, 32'h21};
      xact(1'b1, 3'd2, 32'h20, 32'h1122_3344, rd, er, lat, to);
      model(1'b1, 3'd2, 32'h20, 32'h1122_3344, erd, eer);
      xact(1'b1, 3'd0, 32'h21, 32'h0000_00AA, rd, er, lat, to);
      model(1'b1, 3'd0, 32'h21, 32'h0000_00AA, erd, eer);
      for (int i = 0; i < 3; i++) begin
         xact(1'b0, f3s[i], adr[i], 32'd0, rd, er, lat, to);
         checks++;
         if (to || er !== 1'b0 || rd !== exp_v[i]) begin
            errs++;
            $display("FAIL byte_lane_load[%0d]: got to=%0d err=%b rdata=%h, want 0 0 %h",
                     i, to, er, rd, exp_v[i]);
         end
      end
   endtask

   task automatic test_half();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      bit          to;
      xact(1'b1, 3'd1, 32'h32, 32'h0000_8001, rd, er, lat, to);
      model(1'b1, 3'd1, 32'h32, 32'h0000_8001, erd, eer);
      xact(1'b0, 3'd1, 32'h32, 32'd0, rd, er, lat, to);
      checks++;
      if (to || er !== 1'b0 || rd !== 32'hFFFF_8001) begin
         errs++;
         $display("FAIL lh: got to=%0d err=%b rdata=%h, want 0 0 ffff8001", to, er, rd);
      end
      xact(1'b0, 3'd5, 32'h32, 32'd0, rd, er, lat, to);
      checks++;
      if (to || er !== 1'b0 || rd !== 32'h0000_8001) begin
         errs++;
         $display("FAIL lhu: got to=%0d err=%b rdata=%h, want 0 0 00008001", to, er, rd);
      end
   endtask

   task automatic test_faults();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      bit          to;
      logic        fwe  [4];
      logic [2:0]  ff3  [4];
      logic [31:0] fadr [4];
      logic [31:0] vadr [3];
      fwe  = '{1'b0, 1'b1, 1'b0, 1'b1};
      ff3  = '{3'd2, 3'd1, 3'd2, 3'd3};
      fadr = '{32'h13, 32'h05, 32'h400, 32'h20};
      vadr = '{32'h10, 32'h04, 32'h20};
      for (int i = 0; i < 4; i++) begin
         xact(fwe[i], ff3[i], fadr[i], 32'hCAFE_F00D, rd, er, lat, to);
         checks++;
         if (to || er !== 1'b1 || rd !== 32'd0) begin
            errs++;
            $display("FAIL fault[%0d]: got to=%0d err=%b rdata=%h, want 0 1 00000000", i, to, er, rd);
         end
      end
      for (int i = 0; i < 3; i++) begin
         model(1'b0, 3'd2, vadr[i], 32'd0, erd, eer);
         xact(1'b0, 3'd2, vadr[i], 32'd0, rd, er, lat, to);
         checks++;
         if (to || er !== 1'b0 || rd !== erd) begin
            errs++;
            $display("FAIL fault_mem_unchanged[%0d]: got to=%0d err=%b rdata=%h, want 0 0 %h",
                     i, to, er, rd, erd);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, erd, r0;
      logic        er, eer, e0;
      int          lat, n;
      bit          to;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = '0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      r0 = rsp_rdata; e0 = rsp_err;
      model(1'b0, 3'd2, 32'h20, 32'd0, erd, eer);
      checks++;
      if (rsp_valid !== 1'b1 || r0 !== erd || e0 !== 1'b0) begin
         errs++;
         $display("FAIL bp_first_rsp: got valid=%b rdata=%h err=%b, want 1 %h 0", rsp_valid, r0, e0, erd);
      end
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h24; req_wdata = 32'h1234_5678;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || req_ready !== 1'b0) begin
            errs++;
            $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b, want 1 %h %b 0",
                     c, rsp_valid, rsp_rdata, rsp_err, req_ready, r0, e0);
         end
      end
      @(negedge clk);
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errs++;
         $display("FAIL bp_release: got valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
      end
      model(1'b0, 3'd2, 32'h24, 32'd0, erd, eer);
      xact(1'b0, 3'd2, 32'h24, 32'd0, rd, er, lat, to);
      checks++;
      if (to || er !== 1'b0 || rd !== erd) begin
         errs++;
         $display("FAIL bp_ignored_store: got to=%0d err=%b rdata=%h, want 0 0 %h", to, er, rd, erd);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat, n;
      bit          to;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0 || req_ready !== 1'b0) begin
         errs++;
         $display("FAIL reset_in_wait: got valid=%b err=%b rdata=%h ready=%b, want 0 0 00000000 0",
                  rsp_valid, rsp_err, rsp_rdata, req_ready);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model(1'b0, 3'd2, 32'h40, 32'd0, erd, eer);
      xact(1'b0, 3'd2, 32'h40, 32'd0, rd, er, lat, to);
      checks++;
      if (to || er !== 1'b0 || rd !== erd) begin
         errs++;
         $display("FAIL reset_discards_store: got to=%0d err=%b rdata=%h, want 0 0 %h", to, er, rd, erd);
      end
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h15; req_wdata = '0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      model(1'b0, 3'd0, 32'h15, 32'd0, erd, eer);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== erd) begin
         errs++;
         $display("FAIL lb_before_reset: got valid=%b rdata=%h, want 1 %h", rsp_valid, rsp_rdata, erd);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
         errs++;
         $display("FAIL reset_in_resp: got valid=%b err=%b rdata=%h, want 0 0 00000000",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rsp_ready = 1'b1;
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, wd;
      logic        er, eer, we;
      logic [2:0]  f3;
      int          lat;
      bit          to;
      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 15) == 0) ? 32'h400 + $urandom_range(0, 4095) : $urandom_range(0, 127);
         wd = $urandom;
         model(we, f3, a, wd, erd, eer);
         xact(we, f3, a, wd, rd, er, lat, to);
         checks++;
         if (to || lat != 3 || er !== eer || rd !== erd) begin
            errs++;
            $display("FAIL random[%0d] we=%b f3=%0d addr=%h: got to=%0d lat=%0d err=%b rdata=%h, want 0 3 %b %h",
                     i, we, f3, a, to, lat, er, rd, eer, erd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_sw_lw();
      test_byte_lanes();
      test_half();
      test_faults();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
